// File: rtl/rgmii_pkg.sv
// Shared RGMII definitions: the idle nibble and the transmit mode encoding.
package rgmii_pkg;

  localparam logic [3:0] IDLE_NIBBLE = 4'h0;

  typedef enum logic {
    MODE_GBIT = 1'b0,
    MODE_MII  = 1'b1
  } tx_mode_e;

endpackage

// File: rtl/rgmii_tx_gearbox.sv
// MAC-to-ODDR transmit gearbox: one byte per clock in gigabit mode, one nibble per clock in
// 10/100 mode with the MAC throttled through rdy. Keeps frame and error counters.
module rgmii_tx_gearbox
  import rgmii_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mii_select,
  input  logic [7:0]           rgmii_mac_tx_data,
  input  logic                 rgmii_mac_tx_dv,
  input  logic                 rgmii_mac_tx_er,
  output logic                 rgmii_mac_tx_rdy,
  output logic [3:0]           txd_rise,
  output logic [3:0]           txd_fall,
  output logic                 txctl_rise,
  output logic                 txctl_fall,
  output logic [CNT_WIDTH-1:0] tx_frame_cnt,
  output logic [CNT_WIDTH-1:0] tx_err_cnt
);

  tx_mode_e             r_mode_q;
  logic                 r_phase;
  logic                 r_in_frame;
  logic                 r_err_sticky;
  logic                 r_rdy;
  logic [3:0]           r_hi_nib;
  logic                 r_hi_er;
  logic [3:0]           r_txd_rise;
  logic [3:0]           r_txd_fall;
  logic                 r_txctl_rise;
  logic                 r_txctl_fall;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  logic     w_accept;
  logic     w_eof;
  logic     w_mode_ld;
  logic     w_phase_nx;
  logic     w_rdy_nx;
  tx_mode_e w_mode_nx;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Mode is frozen from the first accepted byte until the frame's end cycle has passed.
  always_comb begin
    w_accept   = rgmii_mac_tx_dv && r_rdy;
    w_eof      = r_in_frame && r_rdy && !rgmii_mac_tx_dv;
    w_mode_ld  = !r_in_frame && !w_accept;
    w_mode_nx  = w_mode_ld ? tx_mode_e'(mii_select) : r_mode_q;
    w_phase_nx = (r_mode_q == MODE_MII) && w_accept;
    w_rdy_nx   = (w_mode_nx == MODE_MII) ? !w_phase_nx : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_q     <= MODE_GBIT;
      r_phase      <= 1'b0;
      r_in_frame   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rdy        <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_mode_q <= w_mode_nx;
      r_phase  <= w_phase_nx;
      r_rdy    <= w_rdy_nx;
      if (w_accept)
        r_in_frame <= 1'b1;
      else if (w_eof)
        r_in_frame <= 1'b0;
      if (w_eof) begin
        r_err_sticky <= 1'b0;
        r_frame_cnt  <= r_frame_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (r_err_sticky)
          r_err_cnt <= sat_inc(r_err_cnt);
      end else if (w_accept && rgmii_mac_tx_er) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  // High nibble and its error bit wait here for the second MII beat.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi_nib <= rgmii_mac_tx_data[7:4];
      r_hi_er  <= rgmii_mac_tx_er;
    end
  end

  // Output beat register feeding the ODDR cells.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txd_rise   <= IDLE_NIBBLE;
      r_txd_fall   <= IDLE_NIBBLE;
      r_txctl_rise <= 1'b0;
      r_txctl_fall <= 1'b0;
    end else begin
      r_txd_rise   <= IDLE_NIBBLE;
      r_txd_fall   <= IDLE_NIBBLE;
      r_txctl_rise <= 1'b0;
      r_txctl_fall <= 1'b0;
      if (r_phase) begin
        r_txd_rise   <= r_hi_nib;
        r_txd_fall   <= r_hi_nib;
        r_txctl_rise <= 1'b1;
        r_txctl_fall <= !r_hi_er;
      end else if (w_accept) begin
        r_txd_rise   <= rgmii_mac_tx_data[3:0];
        r_txd_fall   <= (r_mode_q == MODE_MII) ? rgmii_mac_tx_data[3:0]
                                               : rgmii_mac_tx_data[7:4];
        r_txctl_rise <= 1'b1;
        r_txctl_fall <= !rgmii_mac_tx_er;
      end
    end
  end

  assign rgmii_mac_tx_rdy = r_rdy;
  assign txd_rise         = r_txd_rise;
  assign txd_fall         = r_txd_fall;
  assign txctl_rise       = r_txctl_rise;
  assign txctl_fall       = r_txctl_fall;
  assign tx_frame_cnt     = r_frame_cnt;
  assign tx_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_rgmii_tx_gearbox.sv
// Directed bench for rgmii_tx_gearbox with 4-bit counters so saturation and wrap are reachable.
module tb_rgmii_tx_gearbox;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mii_select;
  logic [7:0]    data;
  logic          dv;
  logic          er;
  logic          rdy;
  logic [3:0]    txd_rise;
  logic [3:0]    txd_fall;
  logic          txctl_rise;
  logic          txctl_fall;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rgmii_tx_gearbox #(.CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .mii_select        (mii_select),
    .rgmii_mac_tx_data (data),
    .rgmii_mac_tx_dv   (dv),
    .rgmii_mac_tx_er   (er),
    .rgmii_mac_tx_rdy  (rdy),
    .txd_rise          (txd_rise),
    .txd_fall          (txd_fall),
    .txctl_rise        (txctl_rise),
    .txctl_fall        (txctl_fall),
    .tx_frame_cnt      (frame_cnt),
    .tx_err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for the current cycle, then move one cycle on.
  task automatic drv(input logic v, input logic e, input logic [7:0] d);
    dv   = v;
    er   = e;
    data = d;
    cyc();
  endtask

  task automatic beat(input string tag, input logic [3:0] r, input logic [3:0] f,
                      input logic cr, input logic cf);
    chk({tag, "_rise"}, txd_rise, r);
    chk({tag, "_fall"}, txd_fall, f);
    chk({tag, "_ctlr"}, txctl_rise, cr);
    chk({tag, "_ctlf"}, txctl_fall, cf);
  endtask

  task automatic do_reset(input logic mii);
    reset = 1'b1; mii_select = mii; dv = 1'b0; er = 1'b0; data = 8'h00;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    reset = 1'b1; mii_select = 1'b0; dv = 1'b0; er = 1'b0; data = 8'h00;
    cyc(); cyc();
    beat("rst", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_fcnt", frame_cnt, 4'h0);
    chk("rst_ecnt", err_cnt, 4'h0);

    // Gigabit frame; dv raised on the reset-release cycle is not accepted.
    reset = 1'b0;
    chk("rel_rdy", rdy, 1'b0);
    drv(1'b1, 1'b0, 8'h55);
    chk("rel_ignored", txctl_rise, 1'b0);
    chk("rel_rdy1", rdy, 1'b1);
    drv(1'b1, 1'b0, 8'h55); beat("g0", 4'h5, 4'h5, 1'b1, 1'b1);
    drv(1'b1, 1'b0, 8'hD5); beat("g1", 4'h5, 4'hD, 1'b1, 1'b1);
    drv(1'b1, 1'b0, 8'hA7); beat("g2", 4'h7, 4'hA, 1'b1, 1'b1);
    drv(1'b0, 1'b0, 8'h00); beat("g_idle", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("g_fcnt", frame_cnt, 4'h1);
    chk("g_ecnt", err_cnt, 4'h0);

    // MII nibbles with dv held across the rdy gap.
    do_reset(1'b1);
    chk("m_rdy0", rdy, 1'b1);
    drv(1'b1, 1'b0, 8'h3C); beat("m_lo", 4'hC, 4'hC, 1'b1, 1'b1); chk("m_rdy1", rdy, 1'b0);
    drv(1'b1, 1'b0, 8'h7E); beat("m_hi", 4'h3, 4'h3, 1'b1, 1'b1); chk("m_rdy2", rdy, 1'b1);
    drv(1'b1, 1'b0, 8'h7E); beat("m2_lo", 4'hE, 4'hE, 1'b1, 1'b1); chk("m_rdy3", rdy, 1'b0);
    drv(1'b0, 1'b0, 8'h00); beat("m2_hi", 4'h7, 4'h7, 1'b1, 1'b1);
    drv(1'b0, 1'b0, 8'h00); beat("m_idle", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("m_fcnt", frame_cnt, 4'h1);

    // Error on byte 2 of 4 in gigabit mode.
    do_reset(1'b0);
    drv(1'b1, 1'b0, 8'h11); beat("e0", 4'h1, 4'h1, 1'b1, 1'b1);
    drv(1'b1, 1'b1, 8'h22); beat("e1", 4'h2, 4'h2, 1'b1, 1'b0);
    drv(1'b1, 1'b0, 8'h33); beat("e2", 4'h3, 4'h3, 1'b1, 1'b1);
    drv(1'b1, 1'b0, 8'h44); beat("e3", 4'h4, 4'h4, 1'b1, 1'b1);
    chk("e_ecnt_mid", err_cnt, 4'h0);
    drv(1'b0, 1'b0, 8'h00); beat("e_idle", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("e_ecnt", err_cnt, 4'h1);
    chk("e_fcnt", frame_cnt, 4'h1);

    // mii_select toggled mid gigabit frame takes effect only on the next frame.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) mii_select = 1'b1;
      drv(1'b1, 1'b0, {4'(i), 4'(9 - i)});
      beat($sformatf("mc%0d", i), 4'(9 - i), 4'(i), 1'b1, 1'b1);
      chk($sformatf("mc%0d_rdy", i), rdy, 1'b1);
    end
    drv(1'b0, 1'b0, 8'h00);
    chk("mc_fcnt", frame_cnt, 4'h1);
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b1, 1'b0, 8'hA5); beat("mc_lo", 4'h5, 4'h5, 1'b1, 1'b1); chk("mc_rdy_lo", rdy, 1'b0);
    drv(1'b0, 1'b0, 8'h00); beat("mc_hi", 4'hA, 4'hA, 1'b1, 1'b1); chk("mc_rdy_hi", rdy, 1'b1);

    // Reset during byte 5 of a frame.
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) drv(1'b1, 1'b1, 8'(i));
    reset = 1'b1;
    drv(1'b1, 1'b0, 8'h55);
    beat("rm", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rm_rdy", rdy, 1'b0);
    reset = 1'b0;
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b0, 1'b0, 8'h00);
    chk("rm_fcnt", frame_cnt, 4'h0);
    chk("rm_ecnt", err_cnt, 4'h0);

    // 15, 16 then 17 errored frames: error count saturates, frame count wraps.
    do_reset(1'b0);
    for (int f = 0; f < 17; f++) begin
      drv(1'b1, 1'b1, 8'hF0);
      drv(1'b0, 1'b0, 8'h00);
      if (f == 14) begin
        chk("s15_fcnt", frame_cnt, 4'hF);
        chk("s15_ecnt", err_cnt, 4'hF);
      end else if (f == 15) begin
        chk("s16_fcnt", frame_cnt, 4'h0);
        chk("s16_ecnt", err_cnt, 4'hF);
      end
    end
    chk("s17_fcnt", frame_cnt, 4'h1);
    chk("s17_ecnt", err_cnt, 4'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
